// File: rtl/multi_width_counter_bank_pkg.sv
// Shared encodings and the per-channel width rule for the multi-width counter bank.
// Imported by the RTL and by the bench so both derive channel widths the same way.
package multi_width_counter_bank_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

   // Width of channel i: each channel is step_w bits wider than the previous one.
   function automatic int wi(input int i, input int base_w, input int step_w);
      return base_w + i * step_w;
   endfunction

endpackage

// File: rtl/multi_width_counter_bank_channel.sv
// One up/down counter of width W with parallel load and wrap/saturate boundaries.
// tc_evt flags, combinationally, an enabled step that starts at the boundary in its direction.
module counter_channel
   import multi_width_counter_bank_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         up_down,
   input  logic         sat_mode,
   output logic [W-1:0] count,
   output logic         tc_evt
);

   logic [W-1:0] count_reg;
   logic [W-1:0] count_next;
   logic         at_max;
   logic         at_min;
   logic         step;

   assign at_max = &count_reg;
   assign at_min = ~|count_reg;
   // Load wins over stepping, so a load cycle never raises an event.
   assign step   = cmd_en & ~load & en;
   assign tc_evt = step & (((up_down == DIR_UP) & at_max) | ((up_down == DIR_DOWN) & at_min));

   always_comb begin
      count_next = count_reg;
      if (cmd_en && load) begin
         count_next = load_val;
      end else if (step) begin
         if (up_down == DIR_UP) begin
            if (!at_max) begin
               count_next = count_reg + 1'b1;
            end else if (sat_mode == MODE_WRAP) begin
               count_next = '0;
            end
         end else begin
            if (!at_min) begin
               count_next = count_reg - 1'b1;
            end else if (sat_mode == MODE_WRAP) begin
               count_next = '1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/multi_width_counter_bank.sv
// Bank of NUM_CH up/down counters of increasing width, addressed one at a time via sel.
// Readback is combinational and zero-extended; the terminal-count pulse is registered.
module multi_width_counter_bank
   import multi_width_counter_bank_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int BASE_W = 5,
   parameter int STEP_W = 1,
   parameter int SEL_W  = 2,
   parameter int OUT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_down,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [OUT_W-1:0] load_val,
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_W-1:0] yout,
   output logic             tc,
   output logic [SEL_W-1:0] tc_ch
);

   logic [OUT_W-1:0]  count_ext [NUM_CH];
   logic [NUM_CH-1:0] tc_evt_vec;
   logic              tc_reg;
   logic [SEL_W-1:0]  tc_ch_reg;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         localparam int W = wi(gi, BASE_W, STEP_W);
         logic [W-1:0] count_w;
         logic         cmd_en_w;

         // Out-of-range sel values match no channel, so those commands fall away.
         assign cmd_en_w = (sel == SEL_W'(gi));

         counter_channel #(
            .W(W)
         ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .cmd_en   (cmd_en_w),
            .load     (load),
            .load_val (load_val[W-1:0]),
            .en       (en),
            .up_down  (up_down),
            .sat_mode (sat_mode),
            .count    (count_w),
            .tc_evt   (tc_evt_vec[gi])
         );

         assign count_ext[gi] = OUT_W'(count_w);
      end
   endgenerate

   always_comb begin
      yout = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel == SEL_W'(i)) begin
            yout = count_ext[i];
         end
      end
   end

   // Only the addressed channel can raise an event, so sel names its source.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tc_reg    <= 1'b0;
         tc_ch_reg <= '0;
      end else begin
         tc_reg <= |tc_evt_vec;
         if (|tc_evt_vec) begin
            tc_ch_reg <= sel;
         end
      end
   end

   assign tc    = tc_reg;
   assign tc_ch = tc_ch_reg;

endmodule

// File: tb/tb_multi_width_counter_bank.sv
// Directed bench for multi_width_counter_bank with the default 5/6/7/8-bit channels.
// Expected values are hand-computed; one line is printed per checked transaction.
module tb_multi_width_counter_bank;
   import multi_width_counter_bank_pkg::*;

   localparam int NUM_CH = 4;
   localparam int BASE_W = 5;
   localparam int STEP_W = 1;
   localparam int SEL_W  = 2;
   localparam int OUT_W  = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             up_down;
   logic             sat_mode;
   logic             load;
   logic [OUT_W-1:0] load_val;
   logic [SEL_W-1:0] sel;
   logic [OUT_W-1:0] yout;
   logic             tc;
   logic [SEL_W-1:0] tc_ch;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_width_counter_bank #(
      .NUM_CH (NUM_CH),
      .BASE_W (BASE_W),
      .STEP_W (STEP_W),
      .SEL_W  (SEL_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up_down  (up_down),
      .sat_mode (sat_mode),
      .load     (load),
      .load_val (load_val),
      .sel      (sel),
      .yout     (yout),
      .tc       (tc),
      .tc_ch    (tc_ch)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s val=0x%0h", tag, got);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cmd();
      en   = 1'b0;
      load = 1'b0;
   endtask

   initial begin
      logic [31:0] ch0_max;
      ch0_max  = (32'd1 << wi(0, BASE_W, STEP_W)) - 1;

      rst_n    = 1'b0;
      en       = 1'b1;
      up_down  = DIR_UP;
      sat_mode = MODE_WRAP;
      load     = 1'b1;
      load_val = 8'hFF;
      sel      = '0;

      // 1: reset holds everything at zero despite active commands
      for (int c = 0; c < 4; c++) begin
         sel  = SEL_W'(c);
         load = ~load;
         tick();
         check_val($sformatf("rst_yout_ch%0d", c), 32'(yout), 32'd0);
         check_val($sformatf("rst_tc_ch%0d", c), 32'(tc), 32'd0);
      end
      #2;
      idle_cmd();
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
         sel = SEL_W'(c);
         #1;
         check_val($sformatf("post_rst_ch%0d", c), 32'(yout), 32'd0);
      end

      // 2: wrap up on channel 0
      sel = 2'd0; load_val = 8'd31; load = 1'b1;
      tick();
      check_val("wrap_load_ch0", 32'(yout), ch0_max);
      load = 1'b0; en = 1'b1; up_down = DIR_UP; sat_mode = MODE_WRAP;
      tick();
      check_val("wrap_yout", 32'(yout), 32'd0);
      check_val("wrap_tc", 32'(tc), 32'd1);
      check_val("wrap_tc_ch", 32'(tc_ch), 32'd0);
      idle_cmd();
      tick();
      check_val("wrap_tc_drop", 32'(tc), 32'd0);
      for (int c = 1; c < NUM_CH; c++) begin
         sel = SEL_W'(c);
         #1;
         check_val($sformatf("wrap_iso_ch%0d", c), 32'(yout), 32'd0);
      end

      // 3: blocked saturate-down gives consecutive tc pulses
      sel = 2'd3; sat_mode = MODE_SAT; up_down = DIR_DOWN; en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_val($sformatf("satdn_yout_%0d", k), 32'(yout), 32'd0);
         check_val($sformatf("satdn_tc_%0d", k), 32'(tc), 32'd1);
         check_val($sformatf("satdn_tc_ch_%0d", k), 32'(tc_ch), 32'd3);
      end
      up_down = DIR_UP;
      tick();
      check_val("satup_yout_1", 32'(yout), 32'd1);
      check_val("satup_tc_1", 32'(tc), 32'd0);
      tick();
      check_val("satup_yout_2", 32'(yout), 32'd2);
      check_val("satup_tc_2", 32'(tc), 32'd0);
      idle_cmd();

      // 4: truncating load on channel 1 then wrap
      sel = 2'd1; load_val = 8'hFF; load = 1'b1;
      tick();
      check_val("trunc_load", 32'(yout), 32'h3F);
      load = 1'b0; en = 1'b1; up_down = DIR_UP; sat_mode = MODE_WRAP;
      tick();
      check_val("trunc_wrap_yout", 32'(yout), 32'h00);
      check_val("trunc_wrap_tc", 32'(tc), 32'd1);
      check_val("trunc_wrap_tc_ch", 32'(tc_ch), 32'd1);
      idle_cmd();

      // 5: load beats en; steps touch only the addressed channel
      sel = 2'd2; load_val = 8'd10; load = 1'b1;
      tick();
      check_val("prio_pre", 32'(yout), 32'd10);
      load_val = 8'd5; load = 1'b1; en = 1'b1; up_down = DIR_UP;
      tick();
      check_val("prio_yout", 32'(yout), 32'd5);
      check_val("prio_tc", 32'(tc), 32'd0);
      check_val("prio_tc_ch_hold", 32'(tc_ch), 32'd1);
      load = 1'b0; en = 1'b1; sel = 2'd2;
      tick();
      check_val("iso_step_ch2", 32'(yout), 32'd6);
      sel = 2'd0;
      tick();
      check_val("iso_step_ch0", 32'(yout), 32'd1);
      idle_cmd();
      sel = 2'd1; #1;
      check_val("iso_hold_ch1", 32'(yout), 32'd0);
      sel = 2'd2; #1;
      check_val("iso_hold_ch2", 32'(yout), 32'd6);
      sel = 2'd3; #1;
      check_val("iso_hold_ch3", 32'(yout), 32'd2);

      // 6: asynchronous reset mid-cycle with ch3 at 100 and tc high
      sel = 2'd3; load_val = 8'd100; load = 1'b1;
      tick();
      check_val("ar_ch3_load", 32'(yout), 32'd100);
      sel = 2'd0; load_val = 8'd31;
      tick();
      load = 1'b0; en = 1'b1; up_down = DIR_UP; sat_mode = MODE_WRAP;
      tick();
      check_val("ar_pre_tc", 32'(tc), 32'd1);
      idle_cmd();
      sel = 2'd3;
      #1;
      check_val("ar_pre_yout", 32'(yout), 32'd100);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("ar_yout", 32'(yout), 32'd0);
      check_val("ar_tc", 32'(tc), 32'd0);
      check_val("ar_tc_ch", 32'(tc_ch), 32'd0);
      #1;
      rst_n = 1'b1;
      en = 1'b1; up_down = DIR_UP;
      tick();
      check_val("ar_first_step", 32'(yout), 32'd1);
      idle_cmd();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_width_counter_bank.md
Name: multi_width_counter_bank

Overview:
Parametrised bank of NUM_CH up/down counters. Channel i is BASE_W + i*STEP_W bits wide. This is the next generation of the team's fixed four-counter selector system. It adds per-command parallel load, a selectable wrap or saturate boundary mode, and a terminal-count pulse. It sits behind a control FSM or register interface that addresses one channel at a time via sel and reads the selected count zero-extended on yout.

Parameters:
NUM_CH, 4, number of counter channels (2..16)
BASE_W, 5, width of channel 0 in bits (>=2)
STEP_W, 1, width increment per channel; channel i width Wi = BASE_W + i*STEP_W
SEL_W, 2, sel width; must satisfy 2**SEL_W >= NUM_CH
OUT_W, 8, yout width; must equal BASE_W + (NUM_CH-1)*STEP_W (widest channel)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
en  input  1  step enable for the addressed channel
up_down  input  1  1 = count up, 0 = count down
sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries
load  input  1  parallel load of the addressed channel
load_val  input  OUT_W  load data; truncated to Wi LSBs for channel i
sel  input  SEL_W  channel address for commands and readback
yout  output  OUT_W  count of channel sel, zero-extended to OUT_W
tc  output  1  registered terminal-count pulse
tc_ch  output  SEL_W  channel index that produced the last tc; valid when tc=1

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: all channel counts 0, tc 0, tc_ch 0. yout therefore reads 0 during and after reset.
- Addressing:
  - Commands apply only to channel sel in the cycle they are presented.
  - All other channels hold their value.
  - sel >= NUM_CH: commands are ignored, yout = 0, no tc.
- Priority per cycle on the addressed channel: load > en > hold.
  - load=1: count <= load_val[Wi-1:0]. en is ignored and no tc is generated.
  - load=0, en=1, up_down=1:
    - count < 2**Wi-1: count+1.
    - count = 2**Wi-1: becomes 0 if sat_mode=0, holds 2**Wi-1 if sat_mode=1.
  - load=0, en=1, up_down=0:
    - count > 0: count-1.
    - count = 0: becomes 2**Wi-1 if sat_mode=0, holds 0 if sat_mode=1.
- Terminal count:
  - tc is registered and asserted for exactly the one cycle after an enabled step that starts at the boundary in the step direction (wrap or blocked saturate). tc_ch captures sel in that same cycle.
  - Consecutive blocked saturate steps give tc high on consecutive cycles.
  - When no qualifying event occurs, tc is 0 and tc_ch holds its last value.
- Readback: yout is combinational from sel and the channel registers. A count update is visible on yout immediately after the updating edge, so there is zero read latency.
- sel, up_down and sat_mode may change every cycle. No state is retained about previous mode or direction.
- Reset mid-operation: counts and tc clear asynchronously on the rst_n falling edge. The first command is accepted on the first rising edge with rst_n high.
- Arithmetic: unsigned, modulo 2**Wi per channel. No carry between channels.

Decomposition:
- Shared constants include file (counter_bank_defs): mode encodings MODE_WRAP=0 and MODE_SAT=1, direction encodings DIR_UP=1 and DIR_DOWN=0, and a width function Wi(i) used by both RTL and bench.
- One sub-module, counter_channel (parameter W). Inputs: clk, rst_n, cmd_en, load, load_val[W-1:0], en, up_down, sat_mode. Outputs: count[W-1:0] and tc_evt, where tc_evt is the combinational boundary event.
- Top level instantiates NUM_CH counter_channel instances in a generate loop, decodes sel into cmd_en, muxes and zero-extends for yout, and registers tc and tc_ch.

Test Plan (defaults: widths 5,6,7,8):
1. Reset: hold rst_n=0 with en=1 and load=1 toggling -> yout=0 for every sel, tc=0. Release, then read all channels -> all 0.
2. Wrap up: sel=0, load_val=31, load; then en=1, up_down=1, sat_mode=0 for 1 cycle -> yout=0, tc=1 with tc_ch=0 for one cycle. Channels 1..3 still read 0.
3. Saturate down: sel=3 (count 0), sat_mode=1, up_down=0, en=1 for 3 cycles -> yout stays 0, tc high 3 consecutive cycles with tc_ch=3. Then up_down=1 for 2 cycles -> yout=2, tc=0.
4. Truncating load: sel=1, load_val=8'hFF, load -> sel=1 reads 8'h3F. Then en up with sat_mode=0 -> 8'h00 and tc pulse.
5. Priority and isolation: sel=2 with count 10; load=1, load_val=5, en=1 in the same cycle -> count 5, tc=0. A step presented with sel=2 then sel=0 on consecutive cycles changes only those two channels.
6. Async reset mid-count: channel 3 counting up at 100; drop rst_n between edges -> yout=0 before the next clk edge, tc=0. After release, a step on channel 3 -> yout=1.
